ad_clk_sel_div: RTL and testbench
=================================

AD_CLK_SEL_DIV -- requirements
Module: ad_clk_sel_div

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 8: number of selectable sample-clock channels, legal range 2..16.
REQ-002 The block SHALL have parameter CNT_W, default 16: divisor and counter width in bits, legal range 4..24.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port sel, input, NUM_CH bits: one-hot channel select, where bit i selects channel i.
REQ-006 The block SHALL have port div_tbl, input, NUM_CH*CNT_W bits: packed per-channel divisors, channel i at bits [i*CNT_W +: CNT_W].
REQ-007 The block SHALL have port ad_clk_out, output, 1 bit: registered divided sample clock for the ADC.
REQ-008 The block SHALL have port ad_clk_en, output, 1 bit: one-cycle pulse in the same cycle that ad_clk_out rises.
REQ-009 The block SHALL have port en_detect, output, 1 bit: high while the two-stage registered copies of sel differ.
REQ-010 The block SHALL have port sw_busy, output, 1 bit: high while a channel switch is pending or in progress.
REQ-011 The block SHALL have port act_ch, output, clog2(NUM_CH) bits: index of the channel currently driving ad_clk_out.

Function
REQ-012 The block SHALL register sel twice (sel_r0, then sel_r1); en_detect SHALL be (sel_r0 != sel_r1), giving a single pulse of exactly one cycle per stable change, 2 cycles after sel changes.
REQ-013 The target channel SHALL be decoded from sel_r1: a one-hot value gives the set bit index; zero or multi-hot gives channel NUM_CH-1.
REQ-014 The active divisor D SHALL be latched from div_tbl of the active channel only at a period boundary; any D < 2 SHALL be treated as 2.
REQ-015 The period counter cnt SHALL run 0..D-1 and wrap to 0; ad_clk_out SHALL be high when cnt < D>>1 and low otherwise, so D=2 gives 1 high / 1 low and D=5 gives 2 high / 3 low.
REQ-016 ad_clk_en SHALL be high in exactly the cycles where cnt == 0.
REQ-017 A period boundary SHALL be the cycle with cnt == D-1; no other cycle may change act_ch or D.
REQ-018 At a boundary where the target differs from act_ch, act_ch SHALL load the target, D SHALL load the target divisor, and cnt SHALL restart at 0.
REQ-019 If sel changes several times within one period, the last decoded target at the boundary SHALL win; if sel returns to act_ch before the boundary, no switch SHALL occur.
REQ-020 A div_tbl change for the active channel SHALL take effect at the next boundary only, with no runt pulse.
REQ-021 sw_busy SHALL be (target != act_ch) OR (switch gap active, see REQ-026).
REQ-022 ad_clk_out SHALL never produce a high or low phase shorter than 1 sys_clk cycle, nor a truncated period, on any switch.

Reset
REQ-023 While rst_n = 0 at a sys_clk rising edge, the block SHALL set sel_r0 = sel_r1 = 0, cnt = 0, act_ch = NUM_CH-1, D = max(2, div_tbl[NUM_CH-1]), and clear the gap state.
REQ-024 During and immediately after reset the outputs SHALL be: ad_clk_out = 0, ad_clk_en = 0, en_detect = 0, sw_busy = 0.
REQ-025 Reset asserted mid-period or mid-switch SHALL abort that period or switch without completing it; the first ad_clk_en after release SHALL occur on the first cycle after release.

Configuration
REQ-026 When macro AD_CLK_SWITCH_GAP_EN is defined, each switch (REQ-018) SHALL first hold ad_clk_out low with ad_clk_en = 0 and cnt frozen at 0 for 4 cycles, with sw_busy high throughout, and the new period SHALL then start at cnt = 0.
REQ-027 When AD_CLK_SWITCH_GAP_EN is undefined, the new period SHALL start in the cycle immediately after the boundary, and the gap logic SHALL be absent.

Verification
REQ-028 With NUM_CH=8, div_tbl ch7 = 4, reset released: ad_clk_out must show a 2-high/2-low pattern, ad_clk_en must pulse every 4 cycles, and act_ch must be 7.
REQ-029 With sel changed from 8'h80 to 8'h02 (ch1 D=6) mid-period: en_detect must be high for 1 cycle 2 cycles later, sw_busy must be high until the ch7 boundary, and then 3-high/3-low periods must follow with act_ch = 1.
REQ-030 With sel = 8'h00, then 8'h06: act_ch must remain 7, and no switch and no sw_busy may occur.
REQ-031 With div_tbl ch1 = 1, then 0: a period of 2 (1 high / 1 low) must result in both cases.
REQ-032 With sel toggling 8'h02 -> 8'h04 -> 8'h02 within one ch1 period: no switch may occur, and en_detect must pulse twice.
REQ-033 With AD_CLK_SWITCH_GAP_EN defined, on a ch7 -> ch1 switch: 4 low cycles with sw_busy = 1 must be inserted, followed by ad_clk_en; with rst_n pulsed low mid-gap, the reset values of REQ-023 and REQ-024 must appear the next cycle.

Source files
------------

// File: rtl/ad_clk_sel_div.sv
// ad_clk_sel_div: one-hot selectable, per-channel divided ADC sample clock whose
// channel/divisor changes land only on period boundaries. Macro AD_CLK_SWITCH_GAP_EN adds a 4-cycle low gap on switch.
module ad_clk_sel_div #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 16
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         sel,
    input  logic [NUM_CH*CNT_W-1:0]   div_tbl,
    output logic                      ad_clk_out,
    output logic                      ad_clk_en,
    output logic                      en_detect,
    output logic                      sw_busy,
    output logic [$clog2(NUM_CH)-1:0] act_ch
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int HC_W = $clog2(NUM_CH + 1);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

`ifdef AD_CLK_SWITCH_GAP_EN
    typedef enum logic [1:0] {ST_START, ST_RUN, ST_GAP} state_t;
`else
    typedef enum logic [1:0] {ST_START, ST_RUN} state_t;
`endif

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   sel_r0_q, sel_r1_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    div_q, div_d;
    logic [CH_W-1:0]     act_q, act_d;
    logic                out_q, out_d;
    logic                en_q, en_d;
    logic [CH_W-1:0]     target;
    logic [CH_W-1:0]     hot_idx;
    logic [HC_W-1:0]     hot_cnt;
    logic [CNT_W-1:0]    target_raw;
    logic [CNT_W-1:0]    target_div;
    logic [CNT_W-1:0]    last_div;
`ifdef AD_CLK_SWITCH_GAP_EN
    logic [1:0]          gap_q, gap_d;
`endif

    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(2)) ? CNT_W'(2) : v;
    endfunction

    // Zero or multi-hot selects fall back to the last channel.
    always_comb begin : decode
        hot_cnt    = '0;
        hot_idx    = '0;
        target_raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_r1_q[i]) begin
                hot_cnt = hot_cnt + HC_W'(1);
                hot_idx = CH_W'(i);
            end
        end
        target = (hot_cnt == HC_W'(1)) ? hot_idx : LAST_CH;
        for (int i = 0; i < NUM_CH; i++) begin
            if (CH_W'(i) == target) target_raw = div_tbl[i*CNT_W +: CNT_W];
        end
    end

    assign target_div = clamp_div(target_raw);
    assign last_div   = clamp_div(div_tbl[(NUM_CH-1)*CNT_W +: CNT_W]);

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        act_d   = act_q;
`ifdef AD_CLK_SWITCH_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            ST_START: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
            ST_RUN: begin
                // The boundary is the only point where divisor or channel may change.
                if (cnt_q == div_q - CNT_W'(1)) begin
                    cnt_d = '0;
                    div_d = target_div;
                    act_d = target;
`ifdef AD_CLK_SWITCH_GAP_EN
                    if (target != act_q) begin
                        state_d = ST_GAP;
                        gap_d   = 2'd3;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef AD_CLK_SWITCH_GAP_EN
            ST_GAP: begin
                gap_d = gap_q - 2'd1;
                if (gap_q == 2'd0) state_d = ST_RUN;
            end
`endif
            default: state_d = ST_START;
        endcase
        out_d = (state_d == ST_RUN) && (cnt_d < (div_d >> 1));
        en_d  = (state_d == ST_RUN) && (cnt_d == '0);
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sel_r0_q <= '0;
            sel_r1_q <= '0;
            state_q  <= ST_START;
            cnt_q    <= '0;
            div_q    <= last_div;
            act_q    <= LAST_CH;
            out_q    <= 1'b0;
            en_q     <= 1'b0;
`ifdef AD_CLK_SWITCH_GAP_EN
            gap_q    <= '0;
`endif
        end else begin
            sel_r0_q <= sel;
            sel_r1_q <= sel_r0_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            act_q    <= act_d;
            out_q    <= out_d;
            en_q     <= en_d;
`ifdef AD_CLK_SWITCH_GAP_EN
            gap_q    <= gap_d;
`endif
        end
    end

    assign ad_clk_out = out_q;
    assign ad_clk_en  = en_q;
    assign en_detect  = (sel_r0_q != sel_r1_q);
    assign act_ch     = act_q;
`ifdef AD_CLK_SWITCH_GAP_EN
    assign sw_busy    = (target != act_q) || (state_q == ST_GAP);
`else
    assign sw_busy    = (target != act_q);
`endif

endmodule

// File: tb/tb_ad_clk_sel_div.sv
// tb_ad_clk_sel_div: directed bench for ad_clk_sel_div with a period-schedule model
// checked every cycle plus hand-computed waveform expectations.
module tb_ad_clk_sel_div;
    localparam int NUM_CH = 8;
    localparam int CNT_W  = 16;
`ifdef AD_CLK_SWITCH_GAP_EN
    localparam int GAP_CYC = 4;
`else
    localparam int GAP_CYC = 0;
`endif

    logic                    sys_clk;
    logic                    rst_n;
    logic [NUM_CH-1:0]       sel;
    logic [NUM_CH*CNT_W-1:0] div_tbl;
    logic                    ad_clk_out;
    logic                    ad_clk_en;
    logic                    en_detect;
    logic                    sw_busy;
    logic [2:0]              act_ch;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    ad_clk_sel_div #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .div_tbl    (div_tbl),
        .ad_clk_out (ad_clk_out),
        .ad_clk_en  (ad_clk_en),
        .en_detect  (en_detect),
        .sw_busy    (sw_busy),
        .act_ch     (act_ch)
    );

    // Clock / reset
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [NUM_CH-1:0] s);
        if ($countones(s) != 1) return NUM_CH - 1;
        for (int i = 0; i < NUM_CH; i++) if (s[i]) return i;
        return NUM_CH - 1;
    endfunction

    function automatic int clampd(input int ch);
        int v;
        v = int'(div_tbl[ch*CNT_W +: CNT_W]);
        return (v < 2) ? 2 : v;
    endfunction

    // Model: each period is described by its start cycle t0 and length m_d.
    int cyc = 0;
    int t0 = 0;
    int m_d = 2;
    int m_act = NUM_CH - 1;
    int m_gap = 0;
    bit m_started = 0;
    bit m_valid = 0;
    logic [NUM_CH-1:0] sh0 = '0;
    logic [NUM_CH-1:0] sh1 = '0;

    initial forever begin
        int tgt;
        @(posedge sys_clk);
        cyc++;
        if (!rst_n) begin
            sh0 = '0; sh1 = '0; m_gap = 0; m_started = 0;
            m_act = NUM_CH - 1; m_d = clampd(NUM_CH - 1); m_valid = 1;
        end else begin
            tgt = decode(sh1);
            if (!m_started) begin
                m_started = 1; t0 = cyc;
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0) t0 = cyc;
            end else if (cyc - 1 - t0 == m_d - 1) begin
                if (tgt != m_act) begin
                    m_act = tgt; m_d = clampd(m_act);
                    if (GAP_CYC > 0) m_gap = GAP_CYC; else t0 = cyc;
                end else begin
                    m_d = clampd(m_act); t0 = cyc;
                end
            end
            sh1 = sh0; sh0 = sel;
        end
    end

    // Compare process: every cycle once the model has seen a reset edge.
    initial forever begin
        logic e_out, e_en, e_busy;
        @(negedge sys_clk);
        if (m_valid) begin
            e_out = 1'b0; e_en = 1'b0;
            if (m_started && m_gap == 0) begin
                e_out = ((cyc - t0) < (m_d / 2));
                e_en  = ((cyc - t0) == 0);
            end
            e_busy = (decode(sh1) != m_act) || (m_gap > 0);
            chk("m_out", ad_clk_out, e_out);
            chk("m_en", ad_clk_en, e_en);
            chk("m_det", en_detect, sh0 != sh1);
            chk("m_busy", sw_busy, e_busy);
            chk("m_act", act_ch, m_act);
        end
    end

    // Driver tasks
    task automatic set_div(input int ch, input int val);
        div_tbl[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic push_pat(input logic [15:0] outs, input logic [15:0] ens, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back({outs[i], ens[i]});
    endtask

    // Checks the current cycle first, then one per following negedge, until exp_q drains.
    task automatic check_pat(input string name, input int exp_act);
        logic [1:0] e;
        bit first;
        first = 1;
        while (exp_q.size() > 0) begin
            if (!first) @(negedge sys_clk);
            first = 0;
            e = exp_q.pop_front();
            chk({name, "_out"}, ad_clk_out, e[1]);
            chk({name, "_en"}, ad_clk_en, e[0]);
            chk({name, "_act"}, act_ch, exp_act);
        end
    endtask

    initial begin
        int cnt_a, cnt_b;
        bit found, seen, prev_busy, busy_sw;
        rst_n = 1'b0;
        sel = 8'h80;
        div_tbl = '0;
        set_div(7, 4); set_div(1, 6); set_div(2, 3); set_div(0, 5);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_out", ad_clk_out, 0); chk("rst_en", ad_clk_en, 0);
        chk("rst_det", en_detect, 0); chk("rst_busy", sw_busy, 0);
        chk("rst_act", act_ch, 7);

        // ch7 D=4 after release: 2 high / 2 low, en every 4 cycles
        step(); rst_n = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        push_pat(16'b11001100, 16'b10001000, 8);
        check_pat("ch7", 7);

        // zero and multi-hot selects keep channel 7
        cnt_a = 0; cnt_b = 0;
        step(); sel = 8'h00;
        repeat (8) begin @(negedge sys_clk); cnt_a += sw_busy; cnt_b += en_detect; end
        step(); sel = 8'h06;
        repeat (8) begin @(negedge sys_clk); cnt_a += sw_busy; cnt_b += en_detect; end
        chk("nohot_busy", cnt_a, 0);
        chk("nohot_det", cnt_b, 2);
        chk("nohot_act", act_ch, 7);

        // switch to ch1 (D=6)
        step(); sel = 8'h02;
        found = 0; seen = 0; prev_busy = 0; busy_sw = 0; cnt_b = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge sys_clk);
            cnt_b += en_detect;
            if (act_ch == 3'd1 && !seen) begin seen = 1; busy_sw = prev_busy; end
            prev_busy = sw_busy;
            if (act_ch == 3'd1 && ad_clk_en) found = 1;
        end
        chk("sw1_found", found, 1);
        chk("sw1_det_once", cnt_b, 1);
        chk("sw1_busy_before", busy_sw, 1);
        push_pat(16'b111000111000, 16'b100000100000, 12);
        check_pat("ch1", 1);

        // 02 -> 04 -> 02 inside one ch1 period
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge sys_clk);
            if (ad_clk_en) found = 1;
        end
        chk("tog_sync", found, 1);
        step(); sel = 8'h04;
        step(); sel = 8'h02;
        cnt_a = 0; cnt_b = 0;
        repeat (12) begin
            @(negedge sys_clk);
            cnt_b += en_detect;
            cnt_a += (act_ch != 3'd1);
        end
        chk("tog_det_twice", cnt_b, 2);
        chk("tog_no_switch", cnt_a, 0);

        // divisor 1 then 0 both clamp to period 2
        for (int k = 0; k < 2; k++) begin
            step(); set_div(1, 1 - k);
            repeat (16) @(negedge sys_clk);
            cnt_a = 0; cnt_b = 0;
            repeat (6) begin
                @(negedge sys_clk);
                cnt_a += ad_clk_out;
                cnt_b += (ad_clk_en != ad_clk_out);
            end
            chk("d2_highs", cnt_a, 3);
            chk("d2_en_eq_out", cnt_b, 0);
        end

        // active-channel divisor change mid-period
        step(); set_div(1, 5);
        repeat (20) @(negedge sys_clk);

        // back to ch7: gap (if built) then first period
        step(); sel = 8'h80;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge sys_clk);
            if (act_ch == 3'd7) found = 1;
        end
        chk("sw7_found", found, 1);
`ifdef AD_CLK_SWITCH_GAP_EN
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge sys_clk);
            chk("gap_out", ad_clk_out, 0); chk("gap_en", ad_clk_en, 0);
            chk("gap_busy", sw_busy, 1);
        end
        @(negedge sys_clk);
        chk("gap_end_en", ad_clk_en, 1);
`else
        chk("sw7_en", ad_clk_en, 1);
        chk("sw7_out", ad_clk_out, 1);
`endif

        // switch to ch2 and reset right after the switch (mid-gap when gap is built)
        step(); sel = 8'h04;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge sys_clk);
            if (act_ch == 3'd2) found = 1;
        end
        chk("sw2_found", found, 1);
        rst_n = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("mrst_out", ad_clk_out, 0); chk("mrst_en", ad_clk_en, 0);
        chk("mrst_det", en_detect, 0); chk("mrst_busy", sw_busy, 0);
        chk("mrst_act", act_ch, 7);
        step(); rst_n = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("mrst_first_en", ad_clk_en, 1);
        repeat (30) @(negedge sys_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
